// File: rtl/mmpu_instr_sequencer.sv
// mmpu_instr_sequencer
//   Accepts one memory-processing instruction at a time, checks its operand
//   window, then sweeps the bitline index 0..ROW_SIZE-1 toward the row-vector
//   stage. The downstream stage can hold the sweep with stall.
//
// Ports
//   clock, reset_n          : rising-edge clock, async active-low reset
//   instr_valid/instr_ready : instruction handshake (ready only when idle)
//   instr_*                 : instruction fields, captured on accept
//   stall                   : downstream hold, honoured only while sweeping
//   mem_op, col_flag, dest_addr, src1_addr, src2_addr, start, endx
//                           : captured instruction fields, stable until next accept
//   bitline, bitline_valid  : current bitline index and its qualifier
//   done                    : one-cycle pulse after the last bitline
//   err                     : one-cycle pulse when an instruction is rejected
module mmpu_instr_sequencer #(
    parameter int ROW_SIZE = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_mem_op,
    input  logic              instr_col_flag,
    input  logic [ADDR_W-1:0] instr_dest,
    input  logic [ADDR_W-1:0] instr_src1,
    input  logic [ADDR_W-1:0] instr_src2,
    input  logic [ADDR_W-1:0] instr_start,
    input  logic [ADDR_W-1:0] instr_endx,
    input  logic              stall,
    output logic [1:0]        mem_op,
    output logic              col_flag,
    output logic [ADDR_W-1:0] dest_addr,
    output logic [ADDR_W-1:0] src1_addr,
    output logic [ADDR_W-1:0] src2_addr,
    output logic [ADDR_W-1:0] start,
    output logic [ADDR_W-1:0] endx,
    output logic [ADDR_W-1:0] bitline,
    output logic              bitline_valid,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CHECK  = 2'b01,
        SWEEP  = 2'b10,
        FINISH = 2'b11
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_BL = ADDR_W'(ROW_SIZE - 1);

    state_t state, state_nxt;
    logic   accept;
    logic   reject;
    logic   advance;

    assign accept  = (state == IDLE) && instr_valid;
    // Range ops in column mode need an ordered source pair as well as a
    // non-empty row window.
    assign reject  = (start > endx) ||
                     (mem_op[1] && col_flag && (src1_addr > src2_addr));
    assign advance = (state == SWEEP) && !stall;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = CHECK;
            CHECK:   state_nxt = reject ? IDLE : SWEEP;
            SWEEP:   if (advance && (bitline == LAST_BL)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; err is qualified by the check in CHECK
    always_comb begin
        instr_ready   = 1'b0;
        bitline_valid = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (state)
            IDLE:    instr_ready   = 1'b1;
            CHECK:   err           = reject;
            SWEEP:   bitline_valid = !stall;
            FINISH:  done          = 1'b1;
            default: ;
        endcase
    end

    // Instruction field capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_op    <= '0;
            col_flag  <= 1'b0;
            dest_addr <= '0;
            src1_addr <= '0;
            src2_addr <= '0;
            start     <= '0;
            endx      <= '0;
        end else if (accept) begin
            mem_op    <= instr_mem_op;
            col_flag  <= instr_col_flag;
            dest_addr <= instr_dest;
            src1_addr <= instr_src1;
            src2_addr <= instr_src2;
            start     <= instr_start;
            endx      <= instr_endx;
        end
    end

    // Bitline counter: parks on the last index through FINISH so it never
    // wraps mid-instruction, then clears on the way back to IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bitline <= '0;
        end else if (state == FINISH) begin
            bitline <= '0;
        end else if (advance && (bitline != LAST_BL)) begin
            bitline <= bitline + 1'b1;
        end
    end

endmodule

// File: tb/tb_mmpu_instr_sequencer.sv
module tb_mmpu_instr_sequencer;

    localparam int ROW_SIZE = 8;
    localparam int ADDR_W   = 10;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        instr_mem_op;
    logic              instr_col_flag;
    logic [ADDR_W-1:0] instr_dest, instr_src1, instr_src2, instr_start, instr_endx;
    logic              stall;
    logic [1:0]        mem_op;
    logic              col_flag;
    logic [ADDR_W-1:0] dest_addr, src1_addr, src2_addr, start, endx, bitline;
    logic              bitline_valid, done, err;

    int checks   = 0;
    int failures = 0;

    mmpu_instr_sequencer #(.ROW_SIZE(ROW_SIZE), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_mem_op(instr_mem_op), .instr_col_flag(instr_col_flag),
        .instr_dest(instr_dest), .instr_src1(instr_src1), .instr_src2(instr_src2),
        .instr_start(instr_start), .instr_endx(instr_endx),
        .stall(stall),
        .mem_op(mem_op), .col_flag(col_flag),
        .dest_addr(dest_addr), .src1_addr(src1_addr), .src2_addr(src2_addr),
        .start(start), .endx(endx),
        .bitline(bitline), .bitline_valid(bitline_valid),
        .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next negedge, leave 1 time unit for combinational settle.
    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic set_fields(input int op, input int col, input int d, input int s1,
                              input int s2, input int st, input int en);
        instr_mem_op   = 2'(op);
        instr_col_flag = 1'(col);
        instr_dest     = ADDR_W'(d);
        instr_src1     = ADDR_W'(s1);
        instr_src2     = ADDR_W'(s2);
        instr_start    = ADDR_W'(st);
        instr_endx     = ADDR_W'(en);
    endtask

    // Offer an instruction for one edge; on return the DUT is in CHECK.
    task automatic send(input int op, input int col, input int d, input int s1,
                        input int s2, input int st, input int en);
        @(negedge clock);
        set_fields(op, col, d, s1, s2, st, en);
        instr_valid = 1'b1;
        #1;
        chk("ready_before_accept", int'(instr_ready), 1);
        @(negedge clock);
        instr_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        stall       = 1'b0;
        set_fields(1, 1, 11, 12, 13, 14, 15);
        #12;
        // Reset values
        chk("rst_ready", int'(instr_ready), 1);
        chk("rst_valid", int'(bitline_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_bitline", int'(bitline), 0);
        chk("rst_mem_op", int'(mem_op), 0);
        chk("rst_dest", int'(dest_addr), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Plain sweep
        send(0, 1, 3, 5, 0, 0, 7);
        chk("s1_check_ready", int'(instr_ready), 0);
        chk("s1_check_valid", int'(bitline_valid), 0);
        chk("s1_check_err", int'(err), 0);
        chk("s1_dest", int'(dest_addr), 3);
        chk("s1_src1", int'(src1_addr), 5);
        chk("s1_col", int'(col_flag), 1);
        for (int i = 0; i < ROW_SIZE; i++) begin
            cyc();
            chk("s1_valid", int'(bitline_valid), 1);
            chk("s1_bitline", int'(bitline), i);
            chk("s1_ready", int'(instr_ready), 0);
            chk("s1_done_early", int'(done), 0);
        end
        cyc();
        chk("s1_done", int'(done), 1);
        chk("s1_fin_valid", int'(bitline_valid), 0);
        chk("s1_fin_ready", int'(instr_ready), 0);
        cyc();
        chk("s1_idle_ready", int'(instr_ready), 1);
        chk("s1_idle_done", int'(done), 0);
        chk("s1_idle_bitline", int'(bitline), 0);

        // Stall for 3 cycles at bitline 4: 11 sweep cycles
        send(0, 1, 3, 5, 0, 0, 7);
        for (int c = 0; c < 11; c++) begin
            @(negedge clock);
            stall = (c >= 4 && c < 7);
            #1;
            chk("s2_bitline", int'(bitline), (c < 4) ? c : (c < 7) ? 4 : c - 3);
            chk("s2_valid", int'(bitline_valid), (c >= 4 && c < 7) ? 0 : 1);
            chk("s2_done_early", int'(done), 0);
        end
        @(negedge clock);
        stall = 1'b1;   // ignored in FINISH
        #1;
        chk("s2_done", int'(done), 1);
        chk("s2_fin_valid", int'(bitline_valid), 0);
        @(negedge clock);
        stall = 1'b0;
        #1;
        chk("s2_idle_ready", int'(instr_ready), 1);

        // Column-mode range op with unordered sources
        send(2, 1, 1, 6, 2, 0, 7);
        chk("s3_err", int'(err), 1);
        chk("s3_valid", int'(bitline_valid), 0);
        chk("s3_ready_check", int'(instr_ready), 0);
        cyc();
        chk("s3_err_gone", int'(err), 0);
        chk("s3_ready", int'(instr_ready), 1);
        chk("s3_valid2", int'(bitline_valid), 0);
        chk("s3_done", int'(done), 0);

        // Same sources but row mode: passes
        send(2, 0, 1, 6, 2, 0, 7);
        chk("s3b_err", int'(err), 0);
        cyc();
        chk("s3b_sweep", int'(bitline_valid), 1);
        for (int i = 1; i < ROW_SIZE + 2; i++) cyc();
        chk("s3b_idle", int'(instr_ready), 1);

        // Inverted window
        send(1, 0, 9, 1, 2, 5, 4);
        chk("s4_err", int'(err), 1);
        cyc();
        chk("s4_err_gone", int'(err), 0);
        chk("s4_ready", int'(instr_ready), 1);
        chk("s4_start", int'(start), 5);
        chk("s4_endx", int'(endx), 4);
        chk("s4_dest", int'(dest_addr), 9);
        chk("s4_op", int'(mem_op), 1);
        chk("s4_done", int'(done), 0);

        // Reset mid-sweep
        send(0, 0, 2, 0, 0, 0, 7);
        for (int i = 0; i < 4; i++) cyc();
        chk("s5_bl3", int'(bitline), 3);
        reset_n = 1'b0;
        #1;
        chk("s5_rst_bitline", int'(bitline), 0);
        chk("s5_rst_valid", int'(bitline_valid), 0);
        chk("s5_rst_ready", int'(instr_ready), 1);
        chk("s5_rst_dest", int'(dest_addr), 0);
        chk("s5_rst_done", int'(done), 0);
        @(negedge clock);
        reset_n = 1'b1;
        send(3, 0, 4, 0, 0, 1, 6);
        chk("s5_new_op", int'(mem_op), 3);
        cyc();
        chk("s5_new_bl", int'(bitline), 0);
        chk("s5_new_valid", int'(bitline_valid), 1);
        for (int i = 1; i < ROW_SIZE + 2; i++) cyc();

        // instr_valid held through a sweep with changing fields
        send(0, 1, 3, 5, 0, 0, 7);
        instr_valid = 1'b1;
        for (int i = 0; i < ROW_SIZE; i++) begin
            @(negedge clock);
            set_fields(1, 0, 20 + i, 30 + i, 40, 2, 3);
            #1;
            chk("s6_dest_hold", int'(dest_addr), 3);
            chk("s6_op_hold", int'(mem_op), 0);
            chk("s6_bl", int'(bitline), i);
        end
        @(negedge clock);
        set_fields(1, 0, 50, 51, 52, 1, 2);
        #1;
        chk("s6_done", int'(done), 1);
        chk("s6_fin_dest", int'(dest_addr), 3);
        @(negedge clock);
        set_fields(2, 0, 60, 61, 62, 0, 6);
        #1;
        chk("s6_idle_ready", int'(instr_ready), 1);
        chk("s6_idle_dest", int'(dest_addr), 3);
        @(negedge clock);
        instr_valid = 1'b0;
        #1;
        chk("s6_acc_dest", int'(dest_addr), 60);
        chk("s6_acc_op", int'(mem_op), 2);
        chk("s6_acc_endx", int'(endx), 6);
        chk("s6_acc_ready", int'(instr_ready), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
